module_keypad_scan: RTL and testbench
=====================================

# module_keypad_scan

Scans a 4x4 matrix keypad and debounces it. Produces the 4-bit code of the last accepted key. It sits directly upstream of module_led: `key_code` drives module_led `in`, so the board LEDs show the last key pressed. Column drive and row sense are active-low on FPGA pins; everything downstream is active-high.

## Interface
- SCAN_TICKS, default 27000: clock cycles per column slot and per debounce sample (1 ms at 27 MHz); must be ≥ 4.
- DEBOUNCE_SAMPLES, default 10: consecutive matching samples needed to accept a press or a release; must be ≥ 2.
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- row_n  in  4  keypad rows, active-low, pulled up externally; asynchronous to clk.
- col_n  out  4  column drive, active-low, exactly one bit low at any time.
- key_code  out  4  last accepted key, code = row*4 + col; feeds module_led `in`.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_down  out  1  high from press acceptance until release acceptance.

## Operation
- row_n passes through a 2-flop synchronizer. All decisions use the synchronized value, called rows.
- Tick counter: counts 0..SCAN_TICKS-1, then wraps. The cycle where the count equals SCAN_TICKS-1 is the *sample instant*. The counter runs in every state.
- Column index col (2 bits): col_n = ~(1 << col).
- State SCAN:
  - At each sample instant with rows == 4'b1111, col increments, wrapping 3 → 0.
  - At a sample instant with any row low: capture row = lowest-index low bit and keep col unchanged. Set match count to 1 and go to DEBOUNCE.
- State DEBOUNCE, evaluated at each sample instant:
  - If the captured row bit is still low, increment match count.
  - When match count reaches DEBOUNCE_SAMPLES: key_code ← {row, col}, key_valid pulses, key_down ← 1, go to HELD with release count 0.
  - If the captured row bit is high: go to SCAN and col increments. No output change.
- State HELD, evaluated at each sample instant:
  - Captured row bit high: release count increments. Captured row bit low: release count clears.
  - When release count reaches DEBOUNCE_SAMPLES: key_down ← 0, go to SCAN, col increments.
  - Other keys pressed while in HELD are ignored.
- key_code holds its value until the next accepted press. It is not cleared on release.
- Multiple rows low in the same column: lowest-index row wins.
- Presses in other columns during DEBOUNCE or HELD are invisible, because only the current column is driven.

## Timing
- Reset values (asserted asynchronously, immediately on rst):
  - col_n = 4'b1110, key_code = 4'h0, key_valid = 0, key_down = 0.
  - State SCAN; tick counter, col, match count, release count and synchronizer all cleared. The synchronizer resets to 4'b1111.
- rst asserted mid-DEBOUNCE or mid-HELD: the press is abandoned and no key_valid is issued. After release, scanning restarts at column 0 with a full slot.
- Registered outputs update on the edge after the sample instant. So key_valid is high exactly in the cycle following the accepting sample instant.
- Column settle time before sampling is SCAN_TICKS-1 cycles. Synchronizer latency is 2 cycles.
- Press latency: a stable press is detected at the first sample instant of its column slot. It is accepted (DEBOUNCE_SAMPLES-1)*SCAN_TICKS cycles later, and key_valid follows 1 cycle after that.
- key_valid never asserts two cycles in a row. At most one key_valid per key_down rising edge.

## Test plan
Benches use SCAN_TICKS=4 and DEBOUNCE_SAMPLES=3.

1. **Reset.** Assert rst asynchronously mid-HELD with key_code=9 → col_n=1110, key_code=0, key_valid=0 and key_down=0 in the same cycle, with no clock edge needed. Release rst → col 0 held for 4 cycles.
2. **Idle scan.** row_n=1111 → col_n steps 1110, 1101, 1011, 0111, 1110, 4 cycles each; key_valid never asserts.
3. **Stable press.** Hold row_n=1011 while col_n=1101 (row 2, col 1) → col_n stays 1101. key_valid pulses once, 8 cycles after the detection sample + 1. key_code=9 and key_down=1.
4. **Bounce reject.** Row 0 in col 3 low for the detection sample plus 1 more sample, then high → no key_valid, key_code unchanged. Scanning resumes with col_n=1110.
5. **Release debounce.** From HELD on key 9, release for 2 samples, re-press for 1, then release for 3 samples → key_down stays 1 until the third consecutive release sample. It then drops, col_n becomes 1011, and key_code stays 9.
6. **Multi-row.** row_n=0101 (rows 1 and 3) in col 0 → accepted key_code=4.

Source files
------------

// File: rtl/module_keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Drives one column low at a time, samples the synchronized rows once per
// column slot, and reports the last accepted key as {row, col}.
// Handshake: key_valid is a single-cycle strobe with no ready; a consumer
// must take key_code in the cycle key_valid is high. key_code stays stable
// until the next strobe, and key_down brackets the accepted press.
// Parameter contract: SCAN_TICKS >= 4, DEBOUNCE_SAMPLES >= 2.
module module_keypad_scan #(
    parameter int SCAN_TICKS       = 27000,
    parameter int DEBOUNCE_SAMPLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_SAMPLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    row_meta;
    logic [3:0]    rows;
    logic [TW-1:0] tick;
    logic          sample;
    logic [1:0]    col, col_nx;
    logic [1:0]    row_sel, row_sel_nx;
    logic [1:0]    low_row;
    logic [CW-1:0] match_cnt, match_nx;
    logic [CW-1:0] rel_cnt, rel_nx;
    logic [3:0]    code_nx;
    logic          valid_nx;
    logic          down_nx;

    // Two-flop synchronizer for the asynchronous, active-low row inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'hF;
            rows     <= 4'hF;
        end else begin
            row_meta <= row_n;
            rows     <= row_meta;
        end
    end

    // Free-running slot counter; its last count is the sample instant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
        end else if (tick == TICK_LAST) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    assign sample = (tick == TICK_LAST);

    // Only the current column is driven low.
    assign col_n = ~(4'b0001 << col);

    // Lowest-index low row wins when several rows are pulled down.
    always_comb begin
        low_row = 2'd0;
        if (!rows[0]) begin
            low_row = 2'd0;
        end else if (!rows[1]) begin
            low_row = 2'd1;
        end else if (!rows[2]) begin
            low_row = 2'd2;
        end else if (!rows[3]) begin
            low_row = 2'd3;
        end
    end

    // State, counters and outputs; all updates land on the edge after a sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col       <= 2'd0;
            row_sel   <= 2'd0;
            match_cnt <= '0;
            rel_cnt   <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_nx;
            col       <= col_nx;
            row_sel   <= row_sel_nx;
            match_cnt <= match_nx;
            rel_cnt   <= rel_nx;
            key_code  <= code_nx;
            key_valid <= valid_nx;
            key_down  <= down_nx;
        end
    end

    // Next-state and output decode; nothing moves except at a sample instant.
    always_comb begin
        state_nx   = state;
        col_nx     = col;
        row_sel_nx = row_sel;
        match_nx   = match_cnt;
        rel_nx     = rel_cnt;
        code_nx    = key_code;
        valid_nx   = 1'b0;
        down_nx    = key_down;

        if (sample) begin
            case (state)
                SCAN: begin
                    if (rows == 4'hF) begin
                        col_nx = col + 1'b1;
                    end else begin
                        // Stay on this column so the same key keeps being sensed.
                        row_sel_nx = low_row;
                        match_nx   = CW'(1);
                        state_nx   = DEBOUNCE;
                    end
                end

                DEBOUNCE: begin
                    if (!rows[row_sel]) begin
                        if (match_cnt == CNT_LAST) begin
                            code_nx  = {row_sel, col};
                            valid_nx = 1'b1;
                            down_nx  = 1'b1;
                            rel_nx   = '0;
                            state_nx = HELD;
                        end else begin
                            match_nx = match_cnt + 1'b1;
                        end
                    end else begin
                        // Bounce: drop the candidate and move on silently.
                        state_nx = SCAN;
                        col_nx   = col + 1'b1;
                    end
                end

                HELD: begin
                    if (rows[row_sel]) begin
                        if (rel_cnt == CNT_LAST) begin
                            down_nx  = 1'b0;
                            rel_nx   = '0;
                            state_nx = SCAN;
                            col_nx   = col + 1'b1;
                        end else begin
                            rel_nx = rel_cnt + 1'b1;
                        end
                    end else begin
                        // Any re-press restarts the release run.
                        rel_nx = '0;
                    end
                end

                default: begin
                    state_nx = SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_keypad_scan.sv
// Directed bench for module_keypad_scan with SCAN_TICKS=4, DEBOUNCE_SAMPLES=3.
// Cycle c counts rising edges since reset release; observation is on the
// falling edge after edge c. Sample instants fall in cycles with c%4 == 3.
module tb_module_keypad_scan;

    logic       clk;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    int vectors;
    int miscompares;
    int c;

    logic [3:0] exp_q[$];
    logic       prev_kv;

    module_keypad_scan #(
        .SCAN_TICKS      (4),
        .DEBOUNCE_SAMPLES(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, miscompares so far %0d", miscompares);
        $fatal(1, "watchdog expired");
    end

    // Single checking task: counts and reports
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at c=%0d: got %b expected %b", tag, c, got, exp);
        end
    endtask

    // Driver tasks
    task automatic go_to(input int target);
        while (c < target) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        row_n = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        c   = 0;
    endtask

    // Scoreboard: every key_valid must match the next expected key code
    always @(negedge clk) begin
        if (key_valid) begin
            check("kv_back_to_back", 4'(prev_kv), 4'd0);
            check("kv_expected", 4'(exp_q.size() > 0), 4'd1);
            if (exp_q.size() > 0) check("kv_code", key_code, exp_q.pop_front());
        end
        prev_kv = key_valid;
    end

    initial begin
        logic [3:0] exp_col;
        vectors     = 0;
        miscompares = 0;
        prev_kv     = 1'b0;
        c           = 0;
        rst         = 1'b1;
        row_n       = 4'hF;

        // ---- reset values and idle scan ----
        repeat (2) @(negedge clk);
        check("rst_col_n", col_n, 4'b1110);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", 4'(key_valid), 4'd0);
        check("rst_key_down", 4'(key_down), 4'd0);
        rst = 1'b0;
        c   = 0;
        for (int k = 0; k < 20; k++) begin
            go_to(k);
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check("idle_col_n", col_n, exp_col);
        end

        // ---- stable press of key 9 (row 2, col 1) ----
        do_reset();
        go_to(4);
        check("press_col_n_c4", col_n, 4'b1101);
        row_n = 4'b1011;
        exp_q.push_back(4'd9);
        go_to(8);
        check("press_col_hold_c8", col_n, 4'b1101);
        check("press_down_early", 4'(key_down), 4'd0);
        go_to(12);
        check("press_col_hold_c12", col_n, 4'b1101);
        go_to(15);
        check("press_valid_c15", 4'(key_valid), 4'd0);
        go_to(16);
        check("press_valid_c16", 4'(key_valid), 4'd1);
        check("press_code", key_code, 4'd9);
        check("press_down", 4'(key_down), 4'd1);
        check("press_col_hold_c16", col_n, 4'b1101);

        // ---- release debounce: 2 releases, 1 re-press, 3 releases ----
        row_n = 4'hF;
        go_to(17);
        check("press_valid_c17", 4'(key_valid), 4'd0);
        go_to(24);
        check("rel_down_c24", 4'(key_down), 4'd1);
        row_n = 4'b1011;
        go_to(28);
        check("rel_down_c28", 4'(key_down), 4'd1);
        row_n = 4'hF;
        go_to(39);
        check("rel_down_c39", 4'(key_down), 4'd1);
        go_to(40);
        check("rel_down_c40", 4'(key_down), 4'd0);
        check("rel_col_n", col_n, 4'b1011);
        check("rel_code_kept", key_code, 4'd9);

        // ---- bounce reject: row 0 in col 3 for two samples only ----
        go_to(44);
        check("bounce_col_n_c44", col_n, 4'b0111);
        row_n = 4'b1110;
        go_to(48);
        check("bounce_col_hold_c48", col_n, 4'b0111);
        go_to(52);
        check("bounce_col_hold_c52", col_n, 4'b0111);
        row_n = 4'hF;
        go_to(55);
        check("bounce_col_hold_c55", col_n, 4'b0111);
        go_to(56);
        check("bounce_col_n_c56", col_n, 4'b1110);
        check("bounce_code_kept", key_code, 4'd9);
        check("bounce_down", 4'(key_down), 4'd0);

        // ---- multi-row: rows 1 and 3 low in col 0 -> key 4 ----
        row_n = 4'b0101;
        exp_q.push_back(4'd4);
        go_to(67);
        check("multi_valid_c67", 4'(key_valid), 4'd0);
        go_to(68);
        check("multi_valid_c68", 4'(key_valid), 4'd1);
        check("multi_code", key_code, 4'd4);
        check("multi_down", 4'(key_down), 4'd1);

        // ---- asynchronous reset mid-HELD on key 9 ----
        do_reset();
        go_to(4);
        row_n = 4'b1011;
        exp_q.push_back(4'd9);
        go_to(20);
        check("held_code", key_code, 4'd9);
        check("held_down", 4'(key_down), 4'd1);
        #2 rst = 1'b1;
        #1;
        check("async_col_n", col_n, 4'b1110);
        check("async_key_code", key_code, 4'h0);
        check("async_key_valid", 4'(key_valid), 4'd0);
        check("async_key_down", 4'(key_down), 4'd0);
        row_n = 4'hF;
        @(negedge clk);
        rst = 1'b0;
        c   = 0;
        for (int k = 0; k < 4; k++) begin
            go_to(k);
            check("restart_col0", col_n, 4'b1110);
        end
        go_to(4);
        check("restart_col1", col_n, 4'b1101);
        check("restart_down", 4'(key_down), 4'd0);

        go_to(8);
        check("exp_q_drained", 4'(exp_q.size()), 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
